time_set_ctrl: RTL and testbench

- Sits directly upstream of the hours/minutes/seconds timekeeping counter and produces its set_time_flag, i_hours and i_minutes inputs.
- Converts three user button levels (mode, increment, decrement) into an edit session:
  - snapshot the running time;
  - edit hours, then minutes;
  - commit with a single-cycle load pulse, or abandon on inactivity timeout.
- Also drives edit-field and blink indications for the display stage.

---
 rtl/time_set_ctrl.sv | 166 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//
// Turns three debounced button levels into a time-edit session for the
// hours/minutes/seconds timekeeping counter: snapshot the running time,
// edit hours, then minutes, and commit with a one-cycle load strobe.
// Inactivity in an edit state abandons the session without a commit.
//
// Ports:
//   clk            system clock, shared with the timekeeping counter
//   rst            asynchronous, active-high reset
//   btn_mode       mode button level (synchronised, debounced)
//   btn_inc        increment button level (synchronised, debounced)
//   btn_dec        decrement button level (synchronised, debounced)
//   cur_hours      running hours from the counter, 0..23
//   cur_minutes    running minutes from the counter, 0..59
//   set_time_flag  one-cycle load strobe to the counter (high only in COMMIT)
//   o_hours        edited hours, feeds the counter's i_hours
//   o_minutes      edited minutes, feeds the counter's i_minutes
//   editing        high while editing hours or minutes
//   edit_field     00 none, 01 hours, 10 minutes
//   blink          blink phase of the field being edited, 0 otherwise
// ---------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int BLINK_HALF     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       set_time_flag,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic       editing,
    output logic [1:0] edit_field,
    output logic       blink
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {IDLE, SET_H, SET_M, COMMIT} state_t;

    state_t        state;
    logic          mode_q, inc_q, dec_q;
    logic [TW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;

    logic       mode_e, inc_e, dec_e;
    logic       step_up, step_dn;
    logic       timed_out;
    logic [4:0] hours_up, hours_dn;
    logic [5:0] minutes_up, minutes_dn;

    // Rising edges only, so a held button produces a single action.
    assign mode_e = btn_mode & ~mode_q;
    assign inc_e  = btn_inc  & ~inc_q;
    assign dec_e  = btn_dec  & ~dec_q;

    // inc and dec together cancel out.
    assign step_up = inc_e & ~dec_e;
    assign step_dn = dec_e & ~inc_e;

    // This quiet cycle is the TIMEOUT_CYCLES-th one since the last entry/edge.
    assign timed_out = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign hours_up   = (o_hours   >= 5'd23) ? 5'd0  : o_hours + 5'd1;
    assign hours_dn   = (o_hours   == 5'd0)  ? 5'd23 : o_hours - 5'd1;
    assign minutes_up = (o_minutes >= 6'd59) ? 6'd0  : o_minutes + 6'd1;
    assign minutes_dn = (o_minutes == 6'd0)  ? 6'd59 : o_minutes - 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mode_q        <= 1'b0;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            idle_cnt      <= '0;
            blink_cnt     <= '0;
            set_time_flag <= 1'b0;
            o_hours       <= '0;
            o_minutes     <= '0;
            editing       <= 1'b0;
            edit_field    <= 2'b00;
            blink         <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every branch sees the
            // pre-edge values of state and counters, like real flops.
            mode_q        <= btn_mode;
            inc_q         <= btn_inc;
            dec_q         <= btn_dec;
            set_time_flag <= 1'b0;

            unique case (state)
                IDLE: begin
                    // Counters are already zero here: every exit to IDLE clears them.
                    if (mode_e) begin
                        state      <= SET_H;
                        o_hours    <= (cur_hours   > 5'd23) ? 5'd0 : cur_hours;
                        o_minutes  <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
                        editing    <= 1'b1;
                        edit_field <= 2'b01;
                    end
                end

                SET_H, SET_M: begin
                    if (mode_e) begin
                        // Mode wins over inc/dec: advance without touching the value.
                        if (state == SET_H) begin
                            state      <= SET_M;
                            edit_field <= 2'b10;
                        end else begin
                            state         <= COMMIT;
                            editing       <= 1'b0;
                            edit_field    <= 2'b00;
                            set_time_flag <= 1'b1;
                        end
                        idle_cnt  <= '0;
                        blink_cnt <= '0;
                        blink     <= 1'b0;
                    end else if (inc_e || dec_e) begin
                        if (state == SET_H) begin
                            if (step_up)      o_hours <= hours_up;
                            else if (step_dn) o_hours <= hours_dn;
                        end else begin
                            if (step_up)      o_minutes <= minutes_up;
                            else if (step_dn) o_minutes <= minutes_dn;
                        end
                        // Show the new value solid right away.
                        idle_cnt  <= '0;
                        blink_cnt <= '0;
                        blink     <= 1'b0;
                    end else if (timed_out) begin
                        // Abandon: o_hours/o_minutes keep their last values.
                        state      <= IDLE;
                        editing    <= 1'b0;
                        edit_field <= 2'b00;
                        idle_cnt   <= '0;
                        blink_cnt  <= '0;
                        blink      <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                        if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                            blink_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end

                COMMIT: begin
                    // Strobe drops via the default above; buttons are ignored.
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Drives directed sessions from the test plan followed by random button
// activity, and compares every output each cycle against a behavioural
// model of the edit session. A small register stands in for the
// timekeeping counter to show the time it loads on set_time_flag.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int TIMEOUT_CYCLES = 30;
    localparam int BLINK_HALF     = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [4:0] cur_hours   = '0;
    logic [5:0] cur_minutes = '0;
    logic       set_time_flag;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic       editing;
    logic [1:0] edit_field;
    logic       blink;

    time_set_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .BLINK_HALF    (BLINK_HALF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .set_time_flag(set_time_flag),
        .o_hours      (o_hours),
        .o_minutes    (o_minutes),
        .editing      (editing),
        .edit_field   (edit_field),
        .blink        (blink)
    );

    always #5 clk = ~clk;

    // Stand-in for the timekeeping counter's load port.
    logic [4:0] tk_hours   = '0;
    logic [5:0] tk_minutes = '0;
    always @(posedge clk) begin
        if (set_time_flag) begin
            tk_hours   <= o_hours;
            tk_minutes <= o_minutes;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. phase: 0 idle, 1 editing hours, 2 editing minutes,
    // 3 commit cycle. quiet counts edge-free cycles in the current field.
    // ------------------------------------------------------------------
    int m_phase, m_h, m_m, m_quiet, m_bc;
    bit m_flag, m_blink;
    bit p_mode, p_inc, p_dec;

    task automatic model_reset();
        m_phase = 0; m_h = 0; m_m = 0; m_quiet = 0; m_bc = 0;
        m_flag = 0; m_blink = 0;
        p_mode = 0; p_inc = 0; p_dec = 0;
    endtask

    task automatic model_clock();
        bit me, ie, de;
        int old;
        me = btn_mode && !p_mode;
        ie = btn_inc  && !p_inc;
        de = btn_dec  && !p_dec;
        p_mode = btn_mode; p_inc = btn_inc; p_dec = btn_dec;
        old    = m_phase;
        m_flag = 0;
        case (m_phase)
            0: if (me) begin
                m_phase = 1;
                m_h     = (int'(cur_hours)   > 23) ? 0 : int'(cur_hours);
                m_m     = (int'(cur_minutes) > 59) ? 0 : int'(cur_minutes);
                m_quiet = 0;
            end
            1, 2: begin
                if (me) begin
                    m_phase = m_phase + 1;
                    m_flag  = (m_phase == 3);
                    m_quiet = 0;
                end else if (ie || de) begin
                    int d;
                    d = (ie && !de) ? 1 : (de && !ie) ? -1 : 0;
                    if (m_phase == 1) m_h = (m_h + 24 + d) % 24;
                    else              m_m = (m_m + 60 + d) % 60;
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == TIMEOUT_CYCLES) begin
                        m_phase = 0;
                        m_quiet = 0;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        if (m_phase != old || ((ie || de) && (old == 1 || old == 2))) begin
            m_blink = 0; m_bc = 0;
        end else if (m_phase == 1 || m_phase == 2) begin
            m_bc++;
            if (m_bc == BLINK_HALF) begin
                m_bc = 0; m_blink = !m_blink;
            end
        end else begin
            m_blink = 0; m_bc = 0;
        end
    endtask

    task automatic compare_all();
        check("set_time_flag", 32'(set_time_flag), 32'(m_flag));
        check("o_hours",       32'(o_hours),       32'(m_h));
        check("o_minutes",     32'(o_minutes),     32'(m_m));
        check("editing",       32'(editing),       32'(m_phase == 1 || m_phase == 2));
        check("edit_field",    32'(edit_field),    (m_phase == 1) ? 32'd1 : (m_phase == 2) ? 32'd2 : 32'd0);
        check("blink",         32'(blink),         32'(m_blink));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_clock();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit m, input bit i, input bit d, input int n);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (n) step();
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        drive(m, i, d, 1);
        drive(0, 0, 0, 1);
    endtask

    task automatic set_cur(input int h, input int m);
        cur_hours   = 5'(h);
        cur_minutes = 6'(m);
    endtask

    initial begin
        int snap_h;
        int quiet_left;
        model_reset();

        // Reset state, checked before any clock edge.
        #1;
        check("rst_flag",  32'(set_time_flag), 32'd0);
        check("rst_hours", 32'(o_hours),       32'd0);
        check("rst_edit",  32'(editing),       32'd0);
        check("rst_field", 32'(edit_field),    32'd0);
        drive(0, 0, 0, 2);
        @(negedge clk) rst = 1'b0;

        // inc in IDLE is ignored.
        repeat (3) press(0, 1, 0);

        // Snapshot 13:45, edit hours, held inc counts once.
        set_cur(13, 45);
        press(1, 0, 0);
        check("snap_edit",  32'(editing),    32'd1);
        check("snap_field", 32'(edit_field), 32'd1);
        check("snap_h",     32'(o_hours),    32'd13);
        check("snap_m",     32'(o_minutes),  32'd45);
        repeat (3) press(0, 1, 0);
        check("inc3_h", 32'(o_hours), 32'd16);
        drive(0, 1, 0, 10);
        drive(0, 0, 0, 1);
        check("hold_h", 32'(o_hours), 32'd17);

        // Hour and minute wrap boundaries.
        repeat (6) press(0, 1, 0);
        check("h23", 32'(o_hours), 32'd23);
        press(0, 1, 0);
        check("h_wrap_up", 32'(o_hours), 32'd0);
        press(0, 0, 1);
        check("h_wrap_dn", 32'(o_hours), 32'd23);
        press(1, 0, 0);
        repeat (14) press(0, 1, 0);
        check("m59", 32'(o_minutes), 32'd59);
        press(0, 1, 0);
        check("m_wrap_up", 32'(o_minutes), 32'd0);
        press(0, 0, 1);
        check("m_wrap_dn", 32'(o_minutes), 32'd59);

        // Timeout boundary: 29 quiet cycles stay, the 30th abandons.
        drive(0, 0, 0, TIMEOUT_CYCLES - 2);
        check("to_29_edit", 32'(editing), 32'd1);
        drive(0, 0, 0, 1);
        check("to_30_edit", 32'(editing), 32'd0);
        check("to_keep_h",  32'(o_hours),   32'd23);
        check("to_keep_m",  32'(o_minutes), 32'd59);

        // Full session 08:30 -> 07:32.
        set_cur(8, 30);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        drive(1, 0, 0, 1);
        check("commit_flag", 32'(set_time_flag), 32'd1);
        check("commit_h",    32'(o_hours),       32'd7);
        check("commit_m",    32'(o_minutes),     32'd32);
        drive(0, 0, 0, 1);
        check("post_flag", 32'(set_time_flag), 32'd0);
        check("post_edit", 32'(editing),       32'd0);
        check("tk_hours",   32'(tk_hours),   32'd7);
        check("tk_minutes", 32'(tk_minutes), 32'd32);

        // Edge on the last quiet cycle keeps the session alive.
        set_cur(31, 63);
        press(1, 0, 0);
        check("clamp_h", 32'(o_hours),   32'd0);
        check("clamp_m", 32'(o_minutes), 32'd0);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, TIMEOUT_CYCLES - 1);
        drive(0, 1, 0, 1);
        check("late_inc_edit", 32'(editing),   32'd1);
        check("late_inc_m",    32'(o_minutes), 32'd1);
        drive(0, 0, 0, TIMEOUT_CYCLES + 3);

        // Asynchronous reset in SET_M.
        set_cur(10, 20);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        rst = 1'b1;
        #1;
        check("arst_flag",  32'(set_time_flag), 32'd0);
        check("arst_hours", 32'(o_hours),       32'd0);
        check("arst_min",   32'(o_minutes),     32'd0);
        check("arst_edit",  32'(editing),       32'd0);
        drive(0, 0, 0, 2);
        @(negedge clk) rst = 1'b0;

        // mode + inc together in SET_H: advance, hours untouched.
        set_cur(5, 6);
        press(1, 0, 0);
        snap_h = int'(o_hours);
        drive(1, 1, 0, 1);
        check("mode_pri_field", 32'(edit_field), 32'd2);
        check("mode_pri_h",     32'(o_hours),    32'(snap_h));
        drive(0, 0, 0, TIMEOUT_CYCLES + 3);

        // Random button activity with occasional long quiet stretches.
        quiet_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) set_cur(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
            if (quiet_left > 0) begin
                quiet_left--;
                drive(0, 0, 0, 1);
            end else begin
                if ($urandom_range(0, 59) == 0) quiet_left = int'($urandom_range(20, 40));
                drive(bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 2) == 0),
                      bit'($urandom_range(0, 2) == 0), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
